// File: rtl/host_instr_feeder.sv
// Host-side instruction feeder: packs 32-bit host writes into 64-bit words, queues them, and issues them to the array.
// Optional macro HOST_INSTR_FEEDER_STATS_EN adds issued_count / stall_count counters.
module host_instr_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int HOST_W     = 32,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              host_wr_valid,
  input  logic [HOST_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              buffer_full,
  output logic [63:0]       accel_instr,
  output logic              accel_instr_issued,
  output logic [LVL_W-1:0]  fifo_level,
`ifdef HOST_INSTR_FEEDER_STATS_EN
  output logic [15:0]       issued_count,
  output logic [15:0]       stall_count,
`endif
  output logic              pack_pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } pack_state_t;

  pack_state_t            state_r;
  pack_state_t            state_s;
  logic [HOST_W-1:0]      lo_r;
  logic [63:0]            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [LVL_W-1:0]       count_r;
  logic [LVL_W-1:0]       count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   beat_s;
  logic                   push_s;
  logic                   pop_s;
  logic [63:0]            accel_instr_r;
  logic                   accel_instr_issued_r;

  // Handshake and FIFO control decode
  always_comb begin
    fifo_full_s   = (count_r == LVL_W'(FIFO_DEPTH));
    fifo_empty_s  = (count_r == {LVL_W{1'b0}});
    host_wr_ready = !fifo_full_s && !flush;
    beat_s        = host_wr_valid && host_wr_ready;
    push_s        = beat_s && (state_r == WAIT_HI);
    // ready already excludes flush for pushes; pops must be blocked explicitly
    pop_s         = !fifo_empty_s && !buffer_full && !flush;
  end

  // Pack FSM next-state logic
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = WAIT_LO;
    end else if (beat_s) begin
      case (state_r)
        WAIT_LO: state_s = WAIT_HI;
        WAIT_HI: state_s = WAIT_LO;
        default: state_s = WAIT_LO;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Pack FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_LO;
    end else begin
      state_r <= state_s;
    end
  end

  // Low-half holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r <= {HOST_W{1'b0}};
    end else if (beat_s && (state_r == WAIT_LO)) begin
      lo_r <= host_wr_data;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {host_wr_data, lo_r};
    end
  end

  // Occupancy next-value logic
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + LVL_W'(1);
      2'b01:   count_s = count_r - LVL_W'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_s;
    end
  end

  // Issue register; NOP whenever nothing can be issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accel_instr_r        <= 64'h0;
      accel_instr_issued_r <= 1'b0;
    end else if (pop_s) begin
      accel_instr_r        <= mem_r[rd_ptr_r];
      accel_instr_issued_r <= 1'b1;
    end else begin
      accel_instr_r        <= 64'h0;
      accel_instr_issued_r <= 1'b0;
    end
  end

`ifdef HOST_INSTR_FEEDER_STATS_EN
  logic [15:0] issued_count_r;
  logic [15:0] stall_count_r;

  // Saturating issue/stall statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_count_r <= 16'h0;
      stall_count_r  <= 16'h0;
    end else if (flush) begin
      issued_count_r <= 16'h0;
      stall_count_r  <= 16'h0;
    end else begin
      if (pop_s && (issued_count_r != 16'hFFFF)) begin
        issued_count_r <= issued_count_r + 16'd1;
      end
      if (!fifo_empty_s && buffer_full && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
    end
  end

  assign issued_count = issued_count_r;
  assign stall_count  = stall_count_r;
`endif

  assign accel_instr        = accel_instr_r;
  assign accel_instr_issued = accel_instr_issued_r;
  assign fifo_level         = count_r;
  assign pack_pending       = (state_r == WAIT_HI);

endmodule

// File: doc/host_instr_feeder.md
Name: host_instr_feeder

Overview:
- Upstream stage of the systolic array top level; drives its 64-bit accelerator_input and obeys its buffer_full back-pressure.
- Accepts 32-bit host writes with a valid/ready handshake and packs them in pairs into 64-bit instruction words.
- Queues the packed words in a local FIFO and issues one word per cycle while the array is not full.
- Drives the all-zero NOP word (opcode field [63:60] = 0) whenever it has nothing to issue.

Parameters:
FIFO_DEPTH, 8, number of 64-bit entries in the instruction FIFO; power of two, at least 2
HOST_W, 32, host write width; fixed at 32, two writes per instruction
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of the FIFO and packing state
host_wr_valid  in  1  host write data valid
host_wr_data  in  32  host write data; low half first, then high half
host_wr_ready  out  1  feeder can accept host_wr_data this cycle
buffer_full  in  1  back-pressure from the array's instruction buffer
accel_instr  out  64  instruction word to the array's accelerator_input; registered
accel_instr_issued  out  1  high for one cycle when accel_instr carries a real, non-NOP issue
fifo_level  out  LVL_W  number of complete instructions queued
pack_pending  out  1  low half captured, high half still outstanding

Behaviour:
- Reset (rst high, asynchronous): accel_instr = 64'h0, accel_instr_issued = 0, fifo_level = 0, pack_pending = 0, FIFO pointers = 0, pack FSM = WAIT_LO, host_wr_ready = 1 on release.
- Pack FSM, two states:
  - WAIT_LO: on a host beat (valid & ready), store data into lo_reg and go to WAIT_HI.
  - WAIT_HI: on a beat, push {host_wr_data, lo_reg} to the FIFO and go to WAIT_LO.
- host_wr_ready = !fifo_full && !flush. This holds in both FSM states, so no low half is accepted while the FIFO is full. A pop in the same cycle does not open ready (no full-bypass).
- Issue: register stage on clk.
  - If the FIFO is not empty and buffer_full == 0: accel_instr <= FIFO head, accel_instr_issued <= 1, pop.
  - Otherwise: accel_instr <= 64'h0, accel_instr_issued <= 0.
  - Latency: a high-half beat at edge N can be issued at edge N+1 at the earliest, visible after N+1.
- buffer_full is sampled as-is and blocks the issue on the same edge. Because the array registers buffer_full, the array must tolerate one extra word; the feeder adds no extra slack.
- Simultaneous push and pop: fifo_level is unchanged; head and tail advance independently.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an LVL_W-bit occupancy count.
- flush high (synchronous, lower priority than rst): the same edge clears the FIFO, the pointers and fifo_level, returns the FSM to WAIT_LO (a pending lo_reg is discarded), and forces accel_instr to NOP. No push or pop occurs that cycle.
- A reset asserted mid-pack discards the half word; after reset the host restarts with a low half.
- host_wr_valid while ready is low: the data is ignored and the host must hold it.

Optional Feature:
- Macro: HOST_INSTR_FEEDER_STATS_EN.
- When defined, adds output port issued_count (16 bits):
  - increments on every cycle where accel_instr_issued is set;
  - saturates at 16'hFFFF;
  - cleared by rst or flush.
- Adds output stall_count (16 bits):
  - increments on each cycle where the FIFO is non-empty and buffer_full == 1;
  - saturates at 16'hFFFF;
  - cleared by rst or flush.
- When not defined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Single instruction: after reset, write 32'hDEAD_0001 then 32'h1000_BEEF with buffer_full = 0 → one cycle later accel_instr = 64'h1000_BEEF_DEAD_0001, accel_instr_issued pulses once, then accel_instr = 0 and fifo_level = 0.
- Back-pressure: hold buffer_full = 1 and write 8 instructions (16 beats) → fifo_level = 8, host_wr_ready = 0, accel_instr stays 0. Release buffer_full → 8 consecutive issues in write order, fifo_level counts down to 0.
- Full with simultaneous pop: with FIFO full, drop buffer_full while the host holds valid → no beat is accepted on the pop cycle; ready reasserts the next cycle with fifo_level = 7.
- Mid-pack flush: write a low half 32'h1111_1111 (pack_pending = 1), then pulse flush → pack_pending = 0 and fifo_level = 0. The next two beats 32'hA, 32'hB issue 64'h0000_000B_0000_000A.
- Async reset mid-stream: assert rst between clock edges with 3 queued instructions → outputs clear immediately without a clock edge; nothing issues after release.
- Stats (macro on): issue 5 instructions with 3 stall cycles → issued_count = 5, stall_count = 3; flush → both 0.
